// File: rtl/rob_unit.sv
// Reorder buffer: in-order retirement, writeback capture, operand look-up
// and branch-mispredict flush for the out-of-order core.
module rob_unit #(
    parameter int ROB_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_signal,
    input  logic [1:0]         issue_type_in,
    input  logic [4:0]         issue_rd_in,
    input  logic [31:0]        issue_addr_in,
    input  logic               issue_pred_taken_in,
    input  logic [31:0]        issue_target_in,
    output logic [ROB_BIT-1:0] rob_tail,
    output logic               rob_full,
    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_entry,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    input  logic [ROB_BIT-1:0] query_entry1,
    input  logic [ROB_BIT-1:0] query_entry2,
    output logic               query_ready1,
    output logic [31:0]        query_value1,
    output logic               query_ready2,
    output logic [31:0]        query_value2,
    output logic               commit_valid,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_value,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               commit_store,
    output logic               rob_clear_up,
    output logic [31:0]        clear_pc
);

    localparam int ROB_SIZE = 1 << ROB_BIT;
    localparam logic [1:0] TY_STORE  = 2'd1;
    localparam logic [1:0] TY_BRANCH = 2'd2;
    localparam logic [ROB_BIT:0]   CNT_FULL = {1'b1, {ROB_BIT{1'b0}}};
    localparam logic [ROB_BIT:0]   CNT_ONE  = 1;
    localparam logic [ROB_BIT-1:0] IDX_ONE  = 1;

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_pred;
    logic [1:0]          r_type   [ROB_SIZE];
    logic [4:0]          r_rd     [ROB_SIZE];
    logic [31:0]         r_value  [ROB_SIZE];
    logic [31:0]         r_addr   [ROB_SIZE];
    logic [31:0]         r_target [ROB_SIZE];

    logic [ROB_BIT-1:0] r_head;
    logic [ROB_BIT-1:0] r_tail;
    logic [ROB_BIT:0]   r_count;

    logic               r_commit_valid;
    logic [4:0]         r_commit_rd;
    logic [31:0]        r_commit_value;
    logic [ROB_BIT-1:0] r_commit_entry;
    logic               r_commit_store;
    logic               r_clear_up;
    logic [31:0]        r_clear_pc;

    logic w_full;
    logic w_issue;
    logic w_commit;
    logic w_taken;
    logic w_is_reg;
    logic w_mispredict;

    assign w_full   = (r_count == CNT_FULL);
    assign w_issue  = issue_signal && !w_full;
    assign w_commit = r_busy[r_head] && r_ready[r_head];
    assign w_taken  = r_value[r_head][0];
    assign w_is_reg = (r_type[r_head] != TY_STORE) &&
                      (r_type[r_head] != TY_BRANCH);
    assign w_mispredict = w_commit && (r_type[r_head] == TY_BRANCH) &&
                          (w_taken != r_pred[r_head]);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_busy         <= '0;
            r_ready        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_value <= '0;
            r_commit_entry <= '0;
            r_commit_store <= 1'b0;
            r_clear_up     <= 1'b0;
            r_clear_pc     <= '0;
        end else if (!rdy_in) begin
            r_commit_valid <= 1'b0;
            r_commit_store <= 1'b0;
            r_clear_up     <= 1'b0;
        end else begin
            r_commit_valid <= w_commit;
            r_commit_store <= w_commit && (r_type[r_head] == TY_STORE);
            r_clear_up     <= w_mispredict;
            if (w_commit) begin
                r_commit_rd    <= w_is_reg ? r_rd[r_head] : 5'd0;
                r_commit_value <= r_value[r_head];
                r_commit_entry <= r_head;
                r_clear_pc     <= w_taken ? r_target[r_head]
                                          : r_addr[r_head] + 32'd4;
            end
            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_busy  <= '0;
                r_ready <= '0;
            end else begin
                // lsb applied first so a same-entry rs broadcast overrides it
                if (lsb_ready && r_busy[lsb_rob_entry]) begin
                    r_ready[lsb_rob_entry] <= 1'b1;
                    r_value[lsb_rob_entry] <= lsb_value;
                end
                if (rs_ready && r_busy[rs_rob_entry]) begin
                    r_ready[rs_rob_entry] <= 1'b1;
                    r_value[rs_rob_entry] <= rs_value;
                end
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + IDX_ONE;
                end
                if (w_issue) begin
                    r_busy[r_tail]   <= 1'b1;
                    r_ready[r_tail]  <= 1'b0;
                    r_type[r_tail]   <= issue_type_in;
                    r_rd[r_tail]     <= issue_rd_in;
                    r_addr[r_tail]   <= issue_addr_in;
                    r_pred[r_tail]   <= issue_pred_taken_in;
                    r_target[r_tail] <= issue_target_in;
                    r_tail           <= r_tail + IDX_ONE;
                end
                if (w_issue && !w_commit) begin
                    r_count <= r_count + CNT_ONE;
                end else if (!w_issue && w_commit) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end

    function automatic logic [32:0] lookup(input logic [ROB_BIT-1:0] e);
        logic [32:0] res;
        res = '0;
        if (r_ready[e]) begin
            res = {1'b1, r_value[e]};
        end else if (rs_ready && rs_rob_entry == e) begin
            res = {1'b1, rs_value};
        end else if (lsb_ready && lsb_rob_entry == e) begin
            res = {1'b1, lsb_value};
        end
        return res;
    endfunction

    always_comb begin
        {query_ready1, query_value1} = lookup(query_entry1);
        {query_ready2, query_value2} = lookup(query_entry2);
    end

    assign rob_full         = w_full;
    assign rob_tail         = r_tail;
    assign commit_valid     = r_commit_valid;
    assign commit_rd        = r_commit_rd;
    assign commit_value     = r_commit_value;
    assign commit_rob_entry = r_commit_entry;
    assign commit_store     = r_commit_store;
    assign rob_clear_up     = r_clear_up;
    assign clear_pc         = r_clear_pc;

endmodule

// File: tb/tb_rob_unit.sv
// Randomized bench for rob_unit against a program-order queue model.
module tb_rob_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_signal;
    logic [1:0]  issue_type_in;
    logic [4:0]  issue_rd_in;
    logic [31:0] issue_addr_in;
    logic        issue_pred_taken_in;
    logic [31:0] issue_target_in;
    logic [3:0]  rob_tail;
    logic        rob_full;
    logic        rs_ready;
    logic [3:0]  rs_rob_entry;
    logic [31:0] rs_value;
    logic        lsb_ready;
    logic [3:0]  lsb_rob_entry;
    logic [31:0] lsb_value;
    logic [3:0]  query_entry1;
    logic [3:0]  query_entry2;
    logic        query_ready1;
    logic [31:0] query_value1;
    logic        query_ready2;
    logic [31:0] query_value2;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_rob_entry;
    logic        commit_store;
    logic        rob_clear_up;
    logic [31:0] clear_pc;

    always #5 clk_in = ~clk_in;

    rob_unit #(.ROB_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_signal(issue_signal), .issue_type_in(issue_type_in),
        .issue_rd_in(issue_rd_in), .issue_addr_in(issue_addr_in),
        .issue_pred_taken_in(issue_pred_taken_in),
        .issue_target_in(issue_target_in),
        .rob_tail(rob_tail), .rob_full(rob_full),
        .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry),
        .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry),
        .lsb_value(lsb_value),
        .query_entry1(query_entry1), .query_entry2(query_entry2),
        .query_ready1(query_ready1), .query_value1(query_value1),
        .query_ready2(query_ready2), .query_value2(query_value2),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_value(commit_value),
        .commit_rob_entry(commit_rob_entry),
        .commit_store(commit_store),
        .rob_clear_up(rob_clear_up), .clear_pc(clear_pc)
    );

    typedef struct {
        int          idx;
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic        pred;
        logic [31:0] tgt;
        bit          done;
        logic [31:0] val;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int find(input int idx);
        foreach (q[i]) if (q[i].idx == idx) return i;
        return -1;
    endfunction

    task automatic qcheck_one(input string tag, input int e,
                              input logic rdy_o, input logic [31:0] val_o);
        int   k;
        logic er;
        logic [31:0] ev;
        k = find(e);
        if (k < 0) return;
        er = 1'b0;
        ev = '0;
        if (q[k].done) begin
            er = 1'b1; ev = q[k].val;
        end else if (rs_ready && int'(rs_rob_entry) == e) begin
            er = 1'b1; ev = rs_value;
        end else if (lsb_ready && int'(lsb_rob_entry) == e) begin
            er = 1'b1; ev = lsb_value;
        end
        chk({tag, "_ready"}, rdy_o, er);
        if (er) chk({tag, "_value"}, val_o, ev);
    endtask

    task automatic wb(input logic [3:0] e, input logic [31:0] v);
        int k;
        k = find(int'(e));
        if (k >= 0) begin
            q[k].done = 1'b1;
            q[k].val  = v;
        end
    endtask

    task automatic tick();
        bit   e_cv, e_cs, e_cl, full0;
        logic [4:0]  e_rd;
        logic [31:0] e_val, e_pc;
        int   e_ent;
        ent_t h;
        e_cv = 0; e_cs = 0; e_cl = 0;
        e_rd = '0; e_val = '0; e_pc = '0; e_ent = 0;
        #1;
        qcheck_one("q1", int'(query_entry1), query_ready1, query_value1);
        qcheck_one("q2", int'(query_entry2), query_ready2, query_value2);
        @(posedge clk_in);
        if (rst_in) begin
            q.delete();
            m_tail = 0;
        end else if (rdy_in) begin
            full0 = (q.size() == 16);
            if (q.size() > 0 && q[0].done) begin
                h     = q[0];
                e_cv  = 1;
                e_ent = h.idx;
                e_rd  = (h.ty == 2'd0) ? h.rd : 5'd0;
                e_val = h.val;
                e_cs  = (h.ty == 2'd1);
                if (h.ty == 2'd2 && h.val[0] != h.pred) begin
                    e_cl = 1;
                    e_pc = h.val[0] ? h.tgt : h.addr + 32'd4;
                end
            end
            if (e_cl) begin
                q.delete();
                m_tail = 0;
            end else begin
                if (lsb_ready) wb(lsb_rob_entry, lsb_value);
                if (rs_ready) wb(rs_rob_entry, rs_value);
                if (e_cv) void'(q.pop_front());
                if (issue_signal && !full0) begin
                    h = '{m_tail, issue_type_in, issue_rd_in, issue_addr_in,
                          issue_pred_taken_in, issue_target_in, 1'b0, '0};
                    q.push_back(h);
                    m_tail = (m_tail + 1) % 16;
                end
            end
        end
        #1;
        chk("commit_valid", commit_valid, e_cv);
        chk("commit_store", commit_store, e_cs);
        chk("rob_clear_up", rob_clear_up, e_cl);
        if (e_cv) begin
            chk("commit_rd", commit_rd, e_rd);
            chk("commit_rob_entry", commit_rob_entry, e_ent);
            if (e_rd != 0) chk("commit_value", commit_value, e_val);
        end
        if (e_cl) chk("clear_pc", clear_pc, e_pc);
        if (rst_in) begin
            chk("rst_commit_rd", commit_rd, 0);
            chk("rst_commit_value", commit_value, 0);
            chk("rst_clear_pc", clear_pc, 0);
        end
        chk("rob_full", rob_full, q.size() == 16);
        chk("rob_tail", rob_tail, m_tail);
        @(negedge clk_in);
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; issue_signal = 0;
        issue_type_in = 0; issue_rd_in = 0; issue_addr_in = 0;
        issue_pred_taken_in = 0; issue_target_in = 0;
        rs_ready = 0; rs_rob_entry = 0; rs_value = 0;
        lsb_ready = 0; lsb_rob_entry = 0; lsb_value = 0;
        query_entry1 = 0; query_entry2 = 0;
    endtask

    task automatic issue(input logic [1:0] ty, input logic [4:0] rd,
                         input logic [31:0] addr, input logic pred,
                         input logic [31:0] tgt);
        idle();
        issue_signal = 1; issue_type_in = ty; issue_rd_in = rd;
        issue_addr_in = addr; issue_pred_taken_in = pred;
        issue_target_in = tgt;
        tick();
        idle();
    endtask

    task automatic rs_wb(input logic [3:0] e, input logic [31:0] v);
        idle();
        rs_ready = 1; rs_rob_entry = e; rs_value = v;
        tick();
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && q.size() > 0; i++) begin
            idle();
            foreach (q[j]) begin
                if (!q[j].done) begin
                    rs_ready = 1;
                    rs_rob_entry = 4'(q[j].idx);
                    rs_value = $urandom;
                    break;
                end
            end
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1;
        tick();
        idle();
    endtask

    initial begin
        int r;
        idle();
        rst_in = 1;
        @(negedge clk_in);
        tick();
        tick();
        idle();

        issue(2'd0, 5'd5, 32'h0, 0, 0);
        rs_wb(4'd0, 32'h1234);
        tick();
        tick();

        do_reset();
        for (int i = 0; i < 17; i++) issue(2'd0, 5'(i + 1), 32'(i * 4), 0, 0);
        rs_wb(4'd0, 32'hAAAA);
        tick();
        issue(2'd0, 5'd9, 32'h40, 0, 0);
        tick();
        drain();

        do_reset();
        issue(2'd0, 5'd1, 32'h0, 0, 0);
        issue(2'd0, 5'd2, 32'h4, 0, 0);
        rs_wb(4'd1, 32'h11);
        tick();
        tick();
        rs_wb(4'd0, 32'h10);
        tick();
        tick();
        tick();

        do_reset();
        issue(2'd2, 5'd0, 32'h100, 0, 32'h200);
        issue(2'd0, 5'd3, 32'h104, 0, 0);
        issue(2'd0, 5'd4, 32'h108, 0, 0);
        rs_wb(4'd1, 32'h5);
        rs_wb(4'd0, 32'h1);
        idle();
        issue_signal = 1; issue_rd_in = 5'd7;
        tick();
        idle();
        tick();
        rs_wb(4'd0, 32'h9);
        tick();
        tick();

        do_reset();
        issue(2'd1, 5'd8, 32'h10, 0, 0);
        idle();
        lsb_ready = 1; lsb_rob_entry = 0; lsb_value = 32'hDEAD;
        tick();
        idle();
        tick();
        tick();

        do_reset();
        for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 0, 0, 0);
        idle();
        query_entry1 = 4'd3; query_entry2 = 4'd2;
        rs_ready = 1; rs_rob_entry = 4'd3; rs_value = 32'd7;
        lsb_ready = 1; lsb_rob_entry = 4'd2; lsb_value = 32'd9;
        tick();
        idle();
        query_entry1 = 4'd3; query_entry2 = 4'd1;
        tick();
        rs_wb(4'd0, 32'h77);
        rdy_in = 0;
        tick();
        tick();
        tick();
        rdy_in = 1;
        tick();
        tick();
        drain();

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rdy_in = ($urandom_range(0, 7) != 0);
            issue_signal = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 15);
            issue_type_in = (r == 0) ? 2'd2 : (r < 4) ? 2'd1 : 2'd0;
            issue_rd_in = 5'($urandom);
            issue_addr_in = $urandom & 32'hFFFF_FFFC;
            issue_pred_taken_in = 1'($urandom);
            issue_target_in = $urandom & 32'hFFFF_FFFC;
            if (q.size() > 0) begin
                rs_ready = 1'($urandom);
                rs_rob_entry = 4'(q[$urandom_range(0, q.size() - 1)].idx);
                lsb_ready = 1'($urandom);
                lsb_rob_entry = 4'(q[$urandom_range(0, q.size() - 1)].idx);
                query_entry1 = 4'(q[$urandom_range(0, q.size() - 1)].idx);
                query_entry2 = 4'(q[$urandom_range(0, q.size() - 1)].idx);
            end else begin
                rs_ready = 1'($urandom);
                rs_rob_entry = 4'($urandom);
                query_entry1 = 4'($urandom);
            end
            rs_value = $urandom;
            lsb_value = $urandom;
            if (lsb_ready && rs_ready && lsb_rob_entry == rs_rob_entry)
                lsb_ready = 0;
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
